// File: rtl/blink_defs.sv
// Shared definitions for the blink receive path: FSM encodings and the
// saturation ceiling used by the width-parameterized counters.
package blink_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_STALLED = 2'd2
  } state_e;

  // All-ones value of a w-bit counter (w up to 32).
  function automatic int unsigned cnt_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a run-length debouncer. rise/fall are
// the accept strobes, high in the cycle before dout takes its new level.
module sync_debounce #(
  parameter int DB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            clean_q, clean_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            accept;

  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    accept   = (s2_q != clean_q) && (db_cnt_q == DB_LAST);
    clean_d  = accept ? s2_q : clean_q;
    // Any sample matching the clean level restarts the run.
    if ((s2_q == clean_q) || accept) db_cnt_d = '0;
    else                             db_cnt_d = db_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      clean_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      clean_q  <= clean_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign dout = clean_q;
  assign rise = accept &  s2_q;
  assign fall = accept & ~s2_q;

endmodule

// File: rtl/blink_monitor.sv
// Blink line receiver: debounced level, edge strobes, rise-to-rise period,
// high time, and stall detection when edges stop arriving.
module blink_monitor
  import blink_defs::*;
#(
  parameter int CNT_W          = 24,
  parameter int DB_CYCLES      = 8,
  parameter int TIMEOUT_CYCLES = 12000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  output logic             blink_clean,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] high_time,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
  // Idle counter is sized from the timeout so it never wraps below it.
  localparam int               IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] TO_MAX  = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] TO_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  state_e            state_q, state_d;
  logic              clean, rise_acc, fall_acc, edge_acc, timeout;
  logic              rise_pulse_q, rise_pulse_d;
  logic              fall_pulse_q, fall_pulse_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_time_q, high_time_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              period_valid_q, period_valid_d;
  logic              stalled_q, stalled_d;

  sync_debounce #(.DB_CYCLES(DB_CYCLES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (blink_in),
    .dout (clean),
    .rise (rise_acc),
    .fall (fall_acc)
  );

  assign edge_acc = rise_acc | fall_acc;
  // An edge in the same cycle as the timeout wins.
  assign timeout  = (idle_cnt_q == TO_LAST) && !edge_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise_acc)     state_d = ST_ARMED;
        else if (timeout) state_d = ST_STALLED;
      end
      ST_ARMED: begin
        if (timeout) state_d = ST_STALLED;
      end
      ST_STALLED: begin
        if (rise_acc) state_d = ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    period_valid_d = (state_q == ST_ARMED) && rise_acc;
    period_d       = period_valid_d ? sat_inc(per_cnt_q) : period_q;
    stalled_d      = (state_d == ST_STALLED);
  end

  always_comb begin
    rise_pulse_d = rise_acc;
    fall_pulse_d = fall_acc;
    // Restarting at 0 on the accepted rise makes per_cnt+1 equal the
    // rise-to-rise distance in cycles at the next accepted rise.
    per_cnt_d    = rise_acc ? '0 : sat_inc(per_cnt_q);
    if (rise_acc)   high_cnt_d = CNT_W'(1);
    else if (clean) high_cnt_d = sat_inc(high_cnt_q);
    else            high_cnt_d = high_cnt_q;
    high_time_d  = fall_acc ? high_cnt_q : high_time_q;
    if (edge_acc)                  idle_cnt_d = '0;
    else if (idle_cnt_q == TO_MAX) idle_cnt_d = idle_cnt_q;
    else                           idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_pulse_q   <= 1'b0;
      fall_pulse_q   <= 1'b0;
      per_cnt_q      <= '0;
      high_cnt_q     <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      idle_cnt_q     <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
    end else begin
      rise_pulse_q   <= rise_pulse_d;
      fall_pulse_q   <= fall_pulse_d;
      per_cnt_q      <= per_cnt_d;
      high_cnt_q     <= high_cnt_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      idle_cnt_q     <= idle_cnt_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
    end
  end

  assign blink_clean  = clean;
  assign rise_pulse   = rise_pulse_q;
  assign fall_pulse   = fall_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign high_time    = high_time_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Bench for blink_monitor: two instances (timeouts 50 and 1000) share the
// input; outputs are compared each cycle against an event-timestamp model.
module tb_blink_monitor;

  localparam int DB   = 4;
  localparam int MAXV = 255;
  localparam int TO_A = 50;
  localparam int TO_B = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       blink_in = 1'b0;
  logic [1:0] clean, rise, fall, pv, stl;
  logic [7:0] per [2];
  logic [7:0] ht  [2];

  blink_monitor #(.CNT_W(8), .DB_CYCLES(DB), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk(clk), .rst(rst), .blink_in(blink_in), .blink_clean(clean[0]),
    .rise_pulse(rise[0]), .fall_pulse(fall[0]), .period(per[0]),
    .period_valid(pv[0]), .high_time(ht[0]), .stalled(stl[0]));

  blink_monitor #(.CNT_W(8), .DB_CYCLES(DB), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk(clk), .rst(rst), .blink_in(blink_in), .blink_clean(clean[1]),
    .rise_pulse(rise[1]), .fall_pulse(fall[1]), .period(per[1]),
    .period_valid(pv[1]), .high_time(ht[1]), .stalled(stl[1]));

  always #5 clk = ~clk;

  // Model: debounced level from the last DB synchronized samples, then
  // everything else from timestamps of accepted edges.
  bit hist[$];
  bit win[$];
  bit m_clean;
  int m_n;
  int m_last_edge [2];
  int m_last_rise [2];
  bit m_armed [2];
  bit m_stall [2];
  bit e_rise, e_fall;
  bit e_pv  [2];
  int e_per [2];
  int e_ht  [2];

  int n_chk, n_pass, cyc;
  int cnt_rise [2];
  int cnt_fall [2];
  int cnt_pv   [2];
  int cnt_hi   [2];
  int fall_cyc, stall_cyc;
  bit prev_stl;
  int r0, f0, h0, p0, p1;

  function automatic int satv(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s[dut%0d]: got %0d expected %0d", tag, d, got, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    win.delete();
    m_clean = 1'b0;
    m_n     = 0;
    e_rise  = 1'b0;
    e_fall  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_last_edge[d] = 0;
      m_last_rise[d] = 0;
      m_armed[d]     = 1'b0;
      m_stall[d]     = 1'b0;
      e_pv[d]        = 1'b0;
      e_per[d]       = 0;
      e_ht[d]        = 0;
    end
  endtask

  task automatic model_step(input bit v);
    bit s2, acc;
    int to;
    s2 = (hist.size() == 2) ? hist[0] : 1'b0;
    hist.push_back(v);
    if (hist.size() > 2) void'(hist.pop_front());
    win.push_back(s2);
    if (win.size() > DB) void'(win.pop_front());
    m_n++;
    acc = (win.size() == DB);
    foreach (win[i]) if (win[i] == m_clean) acc = 1'b0;
    e_rise = acc && !m_clean;
    e_fall = acc &&  m_clean;
    if (acc) m_clean = !m_clean;
    for (int d = 0; d < 2; d++) begin
      to = (d == 0) ? TO_A : TO_B;
      e_pv[d] = 1'b0;
      if (e_rise) begin
        if (m_armed[d]) begin
          e_pv[d]  = 1'b1;
          e_per[d] = satv(m_n - m_last_rise[d]);
        end
        m_armed[d]     = 1'b1;
        m_stall[d]     = 1'b0;
        m_last_rise[d] = m_n;
      end
      if (e_fall) e_ht[d] = satv(m_n - m_last_rise[d]);
      if (acc) m_last_edge[d] = m_n;
      else if (!m_stall[d] && (m_n - m_last_edge[d] == to)) begin
        m_stall[d] = 1'b1;
        m_armed[d] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk("blink_clean",  d, 32'(clean[d]), 32'(m_clean));
      chk("rise_pulse",   d, 32'(rise[d]),  32'(e_rise));
      chk("fall_pulse",   d, 32'(fall[d]),  32'(e_fall));
      chk("period",       d, 32'(per[d]),   32'(e_per[d]));
      chk("period_valid", d, 32'(pv[d]),    32'(e_pv[d]));
      chk("high_time",    d, 32'(ht[d]),    32'(e_ht[d]));
      chk("stalled",      d, 32'(stl[d]),   32'(m_stall[d]));
    end
  endtask

  task automatic cycle(input bit v);
    blink_in = v;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rst) model_step(v);
    else     model_reset();
    check_all();
    for (int d = 0; d < 2; d++) begin
      if (rise[d])  cnt_rise[d]++;
      if (fall[d])  cnt_fall[d]++;
      if (pv[d])    cnt_pv[d]++;
      if (clean[d]) cnt_hi[d]++;
    end
    if (fall[0]) fall_cyc = cyc;
    if (stl[0] && !prev_stl) stall_cyc = cyc;
    prev_stl = stl[0];
  endtask

  initial begin
    model_reset();
    // Reset held while the line toggles.
    cycle(1); cycle(0); cycle(1); cycle(1);
    rst = 1'b1;
    repeat (4) cycle(0);

    // Square wave 10/10, four periods.
    repeat (4) begin
      repeat (10) cycle(1);
      repeat (10) cycle(0);
    end
    chk("sq_period",   0, 32'(per[0]), 20);
    chk("sq_high",     0, 32'(ht[0]), 10);
    chk("sq_pv_count", 0, 32'(cnt_pv[0]), 3);

    // Glitches: 3-sample pulse dropped, 4-sample pulse passed.
    r0 = cnt_rise[0]; h0 = cnt_hi[0];
    repeat (20) cycle(0);
    repeat (3)  cycle(1);
    repeat (20) cycle(0);
    chk("glitch3_rise", 0, 32'(cnt_rise[0] - r0), 0);
    chk("glitch3_high", 0, 32'(cnt_hi[0] - h0), 0);
    r0 = cnt_rise[0]; f0 = cnt_fall[0]; h0 = cnt_hi[0];
    repeat (4)  cycle(1);
    repeat (20) cycle(0);
    chk("glitch4_rise", 0, 32'(cnt_rise[0] - r0), 1);
    chk("glitch4_fall", 0, 32'(cnt_fall[0] - f0), 1);
    chk("glitch4_high", 0, 32'(cnt_hi[0] - h0), 4);

    // Stall after the last accepted edge, then re-arm.
    repeat (40) cycle(0);
    chk("stall_latency", 0, 32'(stall_cyc - fall_cyc), 50);
    chk("stall_level",   0, 32'(stl[0]), 1);
    p0 = cnt_pv[0];
    repeat (2) begin
      repeat (10) cycle(1);
      repeat (10) cycle(0);
    end
    chk("rearm_pv_count", 0, 32'(cnt_pv[0] - p0), 1);
    chk("rearm_period",   0, 32'(per[0]), 20);
    chk("rearm_unstall",  0, 32'(stl[0]), 0);

    // Saturation on the long-timeout instance.
    repeat (150) cycle(1);
    repeat (150) cycle(0);
    chk("sat_high150", 1, 32'(ht[1]), 150);
    repeat (200) cycle(1);
    repeat (20)  cycle(0);
    chk("sat_period",  1, 32'(per[1]), 255);
    chk("sat_high200", 1, 32'(ht[1]), 200);

    // Random segments.
    repeat (60) begin : rnd
      bit lv;
      int len;
      lv  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 30);
      repeat (len) cycle(lv);
    end

    // Asynchronous reset 5 cycles into an armed high phase.
    repeat (10) cycle(0);
    repeat (10) cycle(1);
    repeat (10) cycle(0);
    repeat (11) cycle(1);
    @(posedge clk);
    model_step(1'b1);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    cycle(1); cycle(1);
    rst = 1'b1;
    p0 = cnt_pv[0]; p1 = cnt_pv[1];
    repeat (5)  cycle(0);
    repeat (10) cycle(1);
    repeat (10) cycle(0);
    chk("post_reset_arm_only", 0, 32'(cnt_pv[0] - p0), 0);
    chk("post_reset_arm_only", 1, 32'(cnt_pv[1] - p1), 0);
    repeat (10) cycle(1);
    repeat (10) cycle(0);
    chk("post_reset_pv",     0, 32'(cnt_pv[0] - p0), 1);
    chk("post_reset_period", 0, 32'(per[0]), 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
